disp_scan: RTL and testbench

DISP_SCAN -- requirements
Module: disp_scan

---
 rtl/disp_scan.sv | 127 ++++++++++++
 tb/tb_disp_scan.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan.sv
// Multiplexed 7-segment display scanner with per-slot ghost blanking, leading-zero
// suppression and frame-synchronous double-buffered loading.
module disp_scan #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned SCAN_DIV    = 32'h003f_0000,
  parameter int unsigned DEAD        = 16,
  parameter bit          SEG_ACT_LOW = 1'b0,
  parameter bit          SEL_ACT_LOW = 1'b0
) (
  input  logic                  clkIn,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   in,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lzs,
  input  logic                  load,
  output logic [7:0]            lced,
  output logic [DIGITS-1:0]     sele,
  output logic                  frame_tick,
  output logic                  dbg_state
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam int DEAD_I = int'(DEAD);

  typedef enum logic {ST_DEAD = 1'b0, ST_SHOW = 1'b1} state_t;

  typedef struct packed {
    logic [4*DIGITS-1:0] val;
    logic [DIGITS-1:0]   dpm;
    logic [DIGITS-1:0]   blk;
    logic                lz;
  } disp_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  disp_t           shadow, pending, new_in;
  logic            pend_flag;

  logic            wrap, boundary, show;
  logic [CW-1:0]   cnt_nxt;
  logic [3:0]      cur_nib;
  logic            zero_run, suppress;
  logic [7:0]      seg_full, seg_w;
  logic [DIGITS-1:0] sel_w;

  function automatic logic [7:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 8'hFC;  4'h1: decode = 8'h60;
      4'h2: decode = 8'hDA;  4'h3: decode = 8'hF2;
      4'h4: decode = 8'h66;  4'h5: decode = 8'hB6;
      4'h6: decode = 8'hBE;  4'h7: decode = 8'hE0;
      4'h8: decode = 8'hFE;  4'h9: decode = 8'hF6;
      4'hA: decode = 8'hEE;  4'hB: decode = 8'h3E;
      4'hC: decode = 8'h9C;  4'hD: decode = 8'h7A;
      4'hE: decode = 8'h9E;  default: decode = 8'h8E;
    endcase
  endfunction

  assign new_in    = {in, dp, blank, lzs};
  assign wrap      = (cnt == CNT_LAST);
  assign boundary  = wrap && (idx == IDX_LAST);
  assign cnt_nxt   = wrap ? '0 : cnt + 1'b1;
  assign show      = (int'(cnt) >= DEAD_I);
  assign dbg_state = state;

  // Scan from the top digit down so zero_run says "this nibble and all above are zero".
  always_comb begin
    cur_nib  = '0;
    zero_run = 1'b1;
    suppress = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (shadow.val[4*i +: 4] == 4'h0);
      if (i == int'(idx)) begin
        cur_nib  = shadow.val[4*i +: 4];
        suppress = (i > 0) && zero_run && shadow.lz;
      end
    end
  end

  always_comb begin
    seg_full = decode(cur_nib);
    seg_w    = 8'h00;
    sel_w    = '0;
    if (show && !shadow.blk[idx]) begin
      seg_w      = {suppress ? 7'h00 : seg_full[7:1], shadow.dpm[idx]};
      sel_w[idx] = 1'b1;
    end
  end

  always_ff @(posedge clkIn) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      state      <= ST_DEAD;
      shadow     <= '0;
      pending    <= '0;
      pend_flag  <= 1'b0;
      frame_tick <= 1'b0;
      lced       <= {8{SEG_ACT_LOW}};
      sele       <= {DIGITS{SEL_ACT_LOW}};
    end else begin
      cnt   <= cnt_nxt;
      state <= (int'(cnt_nxt) >= DEAD_I) ? ST_SHOW : ST_DEAD;
      if (wrap) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

      // Shadow only changes on a frame boundary so a frame is never torn.
      if (boundary) begin
        if (load)           shadow <= new_in;
        else if (pend_flag) shadow <= pending;
        pend_flag <= 1'b0;
      end else if (load) begin
        pending   <= new_in;
        pend_flag <= 1'b1;
      end

      frame_tick <= boundary;
      lced       <= seg_w ^ {8{SEG_ACT_LOW}};
      sele       <= sel_w ^ {DIGITS{SEL_ACT_LOW}};
    end
  end

endmodule

// File: tb/tb_disp_scan.sv
// Bench for disp_scan (DIGITS=4, SCAN_DIV=8, DEAD=2): a behavioural display model
// pushes expected {frame_tick, sele, lced} per cycle; each test pops and compares.
module tb_disp_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_v;
  logic [3:0]  dp_v, blank_v;
  logic        lzs_v, load;
  logic [7:0]  lced, lced_l;
  logic [3:0]  sele, sele_l;
  logic        frame_tick, tick_l, dbg_state, dbg_l;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  logic [12:0] exp_q[$];
  logic [12:0] got, exp_w;

  logic [15:0] m_val, p_val;
  logic [3:0]  m_dp, m_blank, p_dp, p_blank;
  logic        m_lzs, p_lzs, m_pf;

  always #5 clk = ~clk;

  disp_scan #(.DIGITS(4), .SCAN_DIV(8), .DEAD(2), .SEG_ACT_LOW(1'b0), .SEL_ACT_LOW(1'b0)) dut (
    .clkIn(clk), .rst(rst), .in(in_v), .dp(dp_v), .blank(blank_v), .lzs(lzs_v), .load(load),
    .lced(lced), .sele(sele), .frame_tick(frame_tick), .dbg_state(dbg_state)
  );

  disp_scan #(.DIGITS(4), .SCAN_DIV(8), .DEAD(2), .SEG_ACT_LOW(1'b1), .SEL_ACT_LOW(1'b1)) u_low (
    .clkIn(clk), .rst(rst), .in(in_v), .dp(dp_v), .blank(blank_v), .lzs(lzs_v), .load(load),
    .lced(lced_l), .sele(sele_l), .frame_tick(tick_l), .dbg_state(dbg_l)
  );

  function automatic logic [7:0] seg_tab(input logic [3:0] n);
    case (n)
      4'h0: return 8'hFC; 4'h1: return 8'h60; 4'h2: return 8'hDA; 4'h3: return 8'hF2;
      4'h4: return 8'h66; 4'h5: return 8'hB6; 4'h6: return 8'hBE; 4'h7: return 8'hE0;
      4'h8: return 8'hFE; 4'h9: return 8'hF6; 4'hA: return 8'hEE; 4'hB: return 8'h3E;
      4'hC: return 8'h9C; 4'hD: return 8'h7A; 4'hE: return 8'h9E; default: return 8'h8E;
    endcase
  endfunction

  // Expected outputs for prescaler value c and digit i, from the displayed model state.
  function automatic logic [12:0] model_out(input int c, input int i, input logic tk);
    logic [3:0]  s;
    logic [7:0]  l;
    logic [15:0] above;
    s = 4'h0;
    l = 8'h00;
    if (c >= 2 && !m_blank[i]) begin
      s[i]  = 1'b1;
      above = m_val >> (4 * i);
      if (i > 0 && m_lzs && above == 16'h0) l = 8'h00;
      else l = seg_tab(4'(above));
      l[0] = m_dp[i];
    end
    return {tk, s, l};
  endfunction

  task automatic model_clear();
    m_val = '0; m_dp = '0; m_blank = '0; m_lzs = 1'b0;
    p_val = '0; p_dp = '0; p_blank = '0; p_lzs = 1'b0; m_pf = 1'b0;
    cyc = 0;
    exp_q.delete();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  // Drives one cycle (optionally a load), pushes the expected output for that edge.
  task automatic drive_cycle(input logic ld, input logic [15:0] v, input logic [3:0] d,
                             input logic [3:0] b, input logic l);
    int  c, i;
    logic tk;
    c  = cyc % 8;
    i  = (cyc / 8) % 4;
    tk = ((cyc % 32) == 31);
    exp_q.push_back(model_out(c, i, tk));
    if (ld) begin
      load = 1'b1; in_v = v; dp_v = d; blank_v = b; lzs_v = l;
    end else begin
      load = 1'b0; in_v = 16'($urandom); dp_v = 4'($urandom_range(0, 15));
      blank_v = 4'($urandom_range(0, 15)); lzs_v = 1'($urandom_range(0, 1));
    end
    if (tk) begin
      if (ld) begin
        m_val = v; m_dp = d; m_blank = b; m_lzs = l;
      end else if (m_pf) begin
        m_val = p_val; m_dp = p_dp; m_blank = p_blank; m_lzs = p_lzs;
      end
      m_pf = 1'b0;
    end else if (ld) begin
      p_val = v; p_dp = d; p_blank = b; p_lzs = l; m_pf = 1'b1;
    end
    @(posedge clk);
    #1;
    load = 1'b0;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b1; in_v = 16'h1234; dp_v = 4'hF; blank_v = 4'h0; lzs_v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (lced !== 8'h00) $display("FAIL reset_lced got=%h exp=00", lced); else pass_cnt++;
    total_cnt++;
    if (sele !== 4'h0) $display("FAIL reset_sele got=%b exp=0000", sele); else pass_cnt++;
    total_cnt++;
    if (frame_tick !== 1'b0) $display("FAIL reset_tick got=%b exp=0", frame_tick); else pass_cnt++;
    total_cnt++;
    if (dbg_state !== 1'b0 || dbg_l !== 1'b0)
      $display("FAIL reset_state got=%b/%b exp=0/0", dbg_state, dbg_l);
    else pass_cnt++;
    rst = 1'b0; load = 1'b0;
    model_clear();
    for (int n = 0; n < 96; n++) begin
      drive_cycle(n == 40, 16'h1234, 4'h0, 4'h0, 1'b0);
      got = {frame_tick, sele, lced}; exp_w = exp_q.pop_front(); total_cnt++;
      if (got !== exp_w) $display("FAIL reset_run cyc=%0d got=%h exp=%h", n, got, exp_w);
      else pass_cnt++;
    end
  endtask

  task automatic test_lzs();
    apply_reset();
    for (int n = 0; n < 64; n++) begin
      drive_cycle(n == 0, 16'h00A0, 4'b0100, 4'h0, 1'b1);
      got = {frame_tick, sele, lced}; exp_w = exp_q.pop_front(); total_cnt++;
      if (got !== exp_w) $display("FAIL lzs cyc=%0d got=%h exp=%h", n, got, exp_w);
      else pass_cnt++;
    end
  endtask

  task automatic test_mid_frame();
    int ticks;
    ticks = 0;
    apply_reset();
    for (int n = 0; n < 96; n++) begin
      drive_cycle(n == 5 || n == 45, (n == 5) ? 16'h1234 : 16'h1111, 4'h1, 4'h0, 1'b0);
      if (frame_tick === 1'b1) ticks++;
      got = {frame_tick, sele, lced}; exp_w = exp_q.pop_front(); total_cnt++;
      if (got !== exp_w) $display("FAIL mid_frame cyc=%0d got=%h exp=%h", n, got, exp_w);
      else pass_cnt++;
    end
    total_cnt++;
    if (ticks !== 3) $display("FAIL tick_count got=%0d exp=3", ticks); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    apply_reset();
    for (int n = 0; n < 128; n++) begin
      v = (n == 10) ? 16'h1234 : (n == 20) ? 16'h5678 : 16'h9ABC;
      drive_cycle(n == 10 || n == 20 || n == 63, v, 4'($urandom_range(0, 15)), 4'h0, 1'b0);
      got = {frame_tick, sele, lced}; exp_w = exp_q.pop_front(); total_cnt++;
      if (got !== exp_w) $display("FAIL back_to_back cyc=%0d got=%h exp=%h", n, got, exp_w);
      else pass_cnt++;
    end
  endtask

  task automatic test_blank();
    apply_reset();
    for (int n = 0; n < 64; n++) begin
      drive_cycle(n == 3, 16'h8888, 4'hF, 4'b0010, 1'b0);
      got = {frame_tick, sele, lced}; exp_w = exp_q.pop_front(); total_cnt++;
      if (got !== exp_w) $display("FAIL blank cyc=%0d got=%h exp=%h", n, got, exp_w);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int n = 0; n < 44; n++) begin
      drive_cycle(n == 2 || n == 42, (n == 2) ? 16'h1234 : 16'h5555, 4'h0, 4'h0, 1'b0);
      got = {frame_tick, sele, lced}; exp_w = exp_q.pop_front(); total_cnt++;
      if (got !== exp_w) $display("FAIL pre_reset cyc=%0d got=%h exp=%h", n, got, exp_w);
      else pass_cnt++;
    end
    rst = 1'b1; load = 1'b1; in_v = 16'h7777;
    @(posedge clk);
    #1;
    total_cnt++;
    if ({frame_tick, sele, lced} !== 13'h0)
      $display("FAIL mid_reset got=%h exp=0000", {frame_tick, sele, lced});
    else pass_cnt++;
    rst = 1'b0; load = 1'b0;
    model_clear();
    for (int n = 0; n < 64; n++) begin
      drive_cycle(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
      got = {frame_tick, sele, lced}; exp_w = exp_q.pop_front(); total_cnt++;
      if (got !== exp_w) $display("FAIL post_reset cyc=%0d got=%h exp=%h", n, got, exp_w);
      else pass_cnt++;
    end
  endtask

  task automatic test_polarity();
    rst = 1'b1; load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (lced_l !== 8'hFF || sele_l !== 4'hF || tick_l !== 1'b0)
      $display("FAIL low_reset got=%h/%b/%b exp=FF/1111/0", lced_l, sele_l, tick_l);
    else pass_cnt++;
    rst = 1'b0;
    model_clear();
    for (int n = 0; n < 64; n++) begin
      drive_cycle(n == 0, 16'h0008, 4'h0, 4'h0, 1'b0);
      exp_w = exp_q.pop_front();
      total_cnt++;
      if ({tick_l, sele_l, lced_l} !== {exp_w[12], ~exp_w[11:8], ~exp_w[7:0]})
        $display("FAIL low_run cyc=%0d got=%h exp=%h", n, {tick_l, sele_l, lced_l},
                 {exp_w[12], ~exp_w[11:8], ~exp_w[7:0]});
      else pass_cnt++;
      if (n == 34) begin
        total_cnt++;
        if (lced_l !== 8'h01 || sele_l !== 4'b1110)
          $display("FAIL low_eight got=%h/%b exp=01/1110", lced_l, sele_l);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; in_v = '0; dp_v = '0; blank_v = '0; lzs_v = 1'b0;
    model_clear();
    test_reset();
    test_lzs();
    test_mid_frame();
    test_back_to_back();
    test_blank();
    test_reset_mid();
    test_polarity();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
